// File: rtl/s2p_sleep_frontend.sv
// Stereo serial-to-parallel front end with all-zero sleep detection.
// Shifts InputL/InputR in MSB first on Dclk. Frame marks the MSB.
// It presents WIDTH-bit stereo words with a ready flag.
// Optional feature: define FRAME_ERR_EN to enable the sticky misframe flag frame_err.
module s2p_sleep_frontend #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ZERO_RUN = 800
) (
    input  logic             Dclk,
    input  logic             Reset_n,
    input  logic             InReady,
    input  logic             Frame,
    input  logic             InputL,
    input  logic             InputR,
    input  logic             clear,
    output logic [WIDTH-1:0] Data_L,
    output logic [WIDTH-1:0] Data_R,
    output logic             S2P_status,
    output logic             sleep_status,
    output logic             frame_err
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned ZcW  = $clog2(ZERO_RUN + 1);
    localparam logic [CntW-1:0] BitStart = CntW'(WIDTH - 2);
    localparam logic [ZcW-1:0]  ZeroRunC = ZcW'(ZERO_RUN);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-2:0]  shift_l_q, shift_l_d;
    logic [WIDTH-2:0]  shift_r_q, shift_r_d;
    logic [WIDTH-1:0]  data_l_q, data_l_d;
    logic [WIDTH-1:0]  data_r_q, data_r_d;
    logic              status_q, status_d;
    logic              sleep_q, sleep_d;
    logic [ZcW-1:0]    zero_cnt_q, zero_cnt_d;
`ifdef FRAME_ERR_EN
    logic              frame_err_q, frame_err_d;
`endif

    // Full words as they stand on the LSB edge.
    logic [WIDTH-1:0] word_l, word_r;
    assign word_l = {shift_l_q, InputL};
    assign word_r = {shift_r_q, InputR};

    // Next-state logic: clear beats everything, InReady abort beats a misframe.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_l_d  = shift_l_q;
        shift_r_d  = shift_r_q;
        data_l_d   = data_l_q;
        data_r_d   = data_r_q;
        status_d   = status_q;
        sleep_d    = sleep_q;
        zero_cnt_d = zero_cnt_q;
`ifdef FRAME_ERR_EN
        frame_err_d = frame_err_q;
`endif
        if (clear) begin
            state_d    = StIdle;
            status_d   = 1'b0;
            sleep_d    = 1'b0;
            zero_cnt_d = '0;
`ifdef FRAME_ERR_EN
            frame_err_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Frame && InReady) begin
                        shift_l_d = {{(WIDTH - 2){1'b0}}, InputL};
                        shift_r_d = {{(WIDTH - 2){1'b0}}, InputR};
                        bit_cnt_d = BitStart;
                        status_d  = 1'b0;
                        state_d   = StShift;
                    end
                end
                StShift: begin
                    if (!InReady) begin
                        state_d = StIdle;
                    end else if (Frame) begin
                        // Misframe: current bit becomes the new MSB.
                        shift_l_d = {{(WIDTH - 2){1'b0}}, InputL};
                        shift_r_d = {{(WIDTH - 2){1'b0}}, InputR};
                        bit_cnt_d = BitStart;
                        status_d  = 1'b0;
`ifdef FRAME_ERR_EN
                        frame_err_d = 1'b1;
`endif
                    end else if (bit_cnt_q == '0) begin
                        data_l_d = word_l;
                        data_r_d = word_r;
                        status_d = 1'b1;
                        state_d  = StIdle;
                        if (word_l == '0 && word_r == '0) begin
                            if (zero_cnt_q != ZeroRunC) begin
                                zero_cnt_d = zero_cnt_q + 1'b1;
                            end
                            sleep_d = (zero_cnt_d == ZeroRunC);
                        end else begin
                            zero_cnt_d = '0;
                            sleep_d    = 1'b0;
                        end
                    end else begin
                        shift_l_d = {shift_l_q[WIDTH-3:0], InputL};
                        shift_r_d = {shift_r_q[WIDTH-3:0], InputR};
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge Dclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_l_q  <= '0;
            shift_r_q  <= '0;
            data_l_q   <= '0;
            data_r_q   <= '0;
            status_q   <= 1'b0;
            sleep_q    <= 1'b0;
            zero_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_l_q  <= shift_l_d;
            shift_r_q  <= shift_r_d;
            data_l_q   <= data_l_d;
            data_r_q   <= data_r_d;
            status_q   <= status_d;
            sleep_q    <= sleep_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

`ifdef FRAME_ERR_EN
    // Sticky misframe flag.
    always_ff @(posedge Dclk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign Data_L       = data_l_q;
    assign Data_R       = data_r_q;
    assign S2P_status   = status_q;
    assign sleep_status = sleep_q;

endmodule

// File: tb/tb_s2p_sleep_frontend.sv
// Bench for s2p_sleep_frontend: word-level reference model plus directed checks.
module tb_s2p_sleep_frontend;

    localparam int ZR = 4;
`ifdef FRAME_ERR_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    logic        Dclk = 1'b0;
    logic        Reset_n;
    logic        InReady;
    logic        Frame;
    logic        InputL;
    logic        InputR;
    logic        clear;
    logic [15:0] Data_L;
    logic [15:0] Data_R;
    logic        S2P_status;
    logic        sleep_status;
    logic        frame_err;

    int total = 0;
    int bad   = 0;
    bit en_cmp = 1'b0;

    s2p_sleep_frontend #(
        .WIDTH    (16),
        .ZERO_RUN (ZR)
    ) dut (
        .Dclk         (Dclk),
        .Reset_n      (Reset_n),
        .InReady      (InReady),
        .Frame        (Frame),
        .InputL       (InputL),
        .InputR       (InputR),
        .clear        (clear),
        .Data_L       (Data_L),
        .Data_R       (Data_R),
        .S2P_status   (S2P_status),
        .sleep_status (sleep_status),
        .frame_err    (frame_err)
    );

    always #5 Dclk = ~Dclk;

    // Reference model: counts received bits and accumulates values arithmetically.
    bit          m_busy = 0;
    int          m_n    = 0;
    int unsigned m_vl   = 0;
    int unsigned m_vr   = 0;
    logic [15:0] m_dl   = '0;
    logic [15:0] m_dr   = '0;
    bit          m_st   = 0;
    bit          m_sl   = 0;
    int          m_zr   = 0;
    bit          m_fe   = 0;

    always @(posedge Dclk or negedge Reset_n) begin
        int unsigned nl, nr;
        int nz;
        if (!Reset_n) begin
            m_busy <= 0; m_n <= 0; m_vl <= 0; m_vr <= 0; m_dl <= '0; m_dr <= '0;
            m_st <= 0; m_sl <= 0; m_zr <= 0; m_fe <= 0;
        end else if (clear) begin
            m_busy <= 0; m_st <= 0; m_sl <= 0; m_zr <= 0; m_fe <= 0;
        end else if (Frame && InReady) begin
            if (m_busy) m_fe <= FE_EN;
            m_busy <= 1; m_n <= 1; m_vl <= 32'(InputL); m_vr <= 32'(InputR); m_st <= 0;
        end else if (m_busy && !InReady) begin
            m_busy <= 0;
        end else if (m_busy) begin
            nl = m_vl * 2 + 32'(InputL);
            nr = m_vr * 2 + 32'(InputR);
            if (m_n == 15) begin
                m_busy <= 0;
                m_dl <= nl[15:0];
                m_dr <= nr[15:0];
                m_st <= 1;
                if (nl == 0 && nr == 0) begin
                    nz = (m_zr + 1 > ZR) ? ZR : m_zr + 1;
                    m_zr <= nz;
                    m_sl <= (nz == ZR);
                end else begin
                    m_zr <= 0;
                    m_sl <= 0;
                end
            end else begin
                m_n <= m_n + 1; m_vl <= nl; m_vr <= nr;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge Dclk);
            if (en_cmp) begin
                chk("model_Data_L", 32'(Data_L), 32'(m_dl));
                chk("model_Data_R", 32'(Data_R), 32'(m_dr));
                chk("model_status", 32'(S2P_status), 32'(m_st));
                chk("model_sleep", 32'(sleep_status), 32'(m_sl));
                chk("model_frame_err", 32'(frame_err), 32'(m_fe));
            end
        end
    end

    // Drives nbits bits of a word, Frame on the first; starts and ends at a negedge.
    task automatic send(input logic [15:0] l, input logic [15:0] r, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            Frame  = (i == 0);
            InputL = l[15-i];
            InputR = r[15-i];
            @(negedge Dclk);
            if (i == 0) chk("status_drop", 32'(S2P_status), 32'd0);
        end
        Frame = 1'b0;
    endtask

    task automatic idle(input int n);
        Frame = 1'b0; InputL = 1'b0; InputR = 1'b0;
        repeat (n) @(negedge Dclk);
    endtask

    logic [15:0] wl, wr;

    initial begin
        Reset_n = 1'b0; InReady = 1'b1; Frame = 1'b0; InputL = 1'b0; InputR = 1'b0;
        clear = 1'b0;
        repeat (2) @(negedge Dclk);
        chk("rst_Data_L", 32'(Data_L), 32'd0);
        chk("rst_status", 32'(S2P_status), 32'd0);
        chk("rst_sleep", 32'(sleep_status), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        Reset_n = 1'b1;
        en_cmp  = 1'b1;
        idle(2);

        // 1: single word, ready after the 16th edge
        send(16'hA5C3, 16'h0F01, 16);
        chk("t1_Data_L", 32'(Data_L), 32'h0000A5C3);
        chk("t1_Data_R", 32'(Data_R), 32'h00000F01);
        chk("t1_status", 32'(S2P_status), 32'd1);
        idle(2);
        chk("t1_status_hold", 32'(S2P_status), 32'd1);

        // 2: back-to-back words
        send(16'h1234, 16'h8001, 16);
        chk("t2_status_w1", 32'(S2P_status), 32'd1);
        send(16'hFFFF, 16'h0000, 16);
        chk("t2_Data_L", 32'(Data_L), 32'h0000FFFF);
        chk("t2_Data_R", 32'(Data_R), 32'h00000000);
        chk("t2_status_w2", 32'(S2P_status), 32'd1);

        // 3: sleep after ZR zero words, saturate, then wake on a non-zero word
        for (int k = 0; k < 3; k++) send(16'h0000, 16'h0000, 16);
        chk("t3_sleep_3", 32'(sleep_status), 32'd0);
        send(16'h0000, 16'h0000, 16);
        chk("t3_sleep_4", 32'(sleep_status), 32'd1);
        send(16'h0000, 16'h0000, 16);
        chk("t3_sleep_sat", 32'(sleep_status), 32'd1);
        send(16'h0001, 16'h0000, 16);
        chk("t3_wake", 32'(sleep_status), 32'd0);
        chk("t3_Data_L", 32'(Data_L), 32'h00000001);

        // 4: misframe at bit 8, then the new word lands 16 edges after its Frame
        wl = 16'hC3A5; wr = 16'h5AA5;
        send(16'hDEAD, 16'hBEEF, 8);
        send(wl, wr, 15);
        chk("t4_Data_kept", 32'(Data_L), 32'h00000001);
        chk("t4_status", 32'(S2P_status), 32'd0);
        chk("t4_frame_err", 32'(frame_err), 32'(FE_EN));
        InputL = wl[0]; InputR = wr[0];
        @(negedge Dclk);
        chk("t4_Data_L", 32'(Data_L), 32'h0000C3A5);
        chk("t4_Data_R", 32'(Data_R), 32'h00005AA5);
        chk("t4_status_new", 32'(S2P_status), 32'd1);

        // InReady abort: partial word dropped, data kept
        send(16'hFFFF, 16'hFFFF, 5);
        InReady = 1'b0;
        @(negedge Dclk);
        InReady = 1'b1;
        idle(16);
        chk("abort_Data_L", 32'(Data_L), 32'h0000C3A5);
        chk("abort_status", 32'(S2P_status), 32'd0);
        chk("abort_frame_err", 32'(frame_err), 32'(FE_EN));

        // 6: clear together with Frame
        for (int k = 0; k < 4; k++) send(16'h0000, 16'h0000, 16);
        chk("t6_sleep_pre", 32'(sleep_status), 32'd1);
        clear = 1'b1; Frame = 1'b1; InputL = 1'b1; InputR = 1'b1;
        @(negedge Dclk);
        clear = 1'b0; Frame = 1'b0;
        chk("t6_status", 32'(S2P_status), 32'd0);
        chk("t6_sleep", 32'(sleep_status), 32'd0);
        chk("t6_frame_err", 32'(frame_err), 32'd0);
        idle(17);
        chk("t6_no_accept", 32'(S2P_status), 32'd0);
        chk("t6_Data_kept", 32'(Data_L), 32'h00000000);
        for (int k = 0; k < 3; k++) send(16'h0000, 16'h0000, 16);
        chk("t6_zero_restart", 32'(sleep_status), 32'd0);

        // 5: async reset mid-sleep and mid-word
        send(16'h0000, 16'h0000, 16);
        chk("t5_sleep_pre", 32'(sleep_status), 32'd1);
        send(16'h8001, 16'h7FFE, 6);
        #3 Reset_n = 1'b0;
        #1;
        chk("t5_async_Data_L", 32'(Data_L), 32'd0);
        chk("t5_async_Data_R", 32'(Data_R), 32'd0);
        chk("t5_async_status", 32'(S2P_status), 32'd0);
        chk("t5_async_sleep", 32'(sleep_status), 32'd0);
        chk("t5_async_frame_err", 32'(frame_err), 32'd0);
        @(negedge Dclk);
        Reset_n = 1'b1;
        InReady = 1'b0;
        wl = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            Frame = (i == 0); InputL = wl[15-i]; InputR = wl[15-i];
            @(negedge Dclk);
        end
        Frame = 1'b0;
        idle(2);
        chk("t5_ignored_status", 32'(S2P_status), 32'd0);
        chk("t5_ignored_Data", 32'(Data_L), 32'd0);
        InReady = 1'b1;
        send(16'h5A5A, 16'hA5A5, 16);
        chk("t5_after_Data_L", 32'(Data_L), 32'h00005A5A);
        chk("t5_after_Data_R", 32'(Data_R), 32'h0000A5A5);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
